// File: rtl/uart_byte_receiver.sv
// rtl/uart_byte_receiver.sv - 8N1 UART byte receiver with framing-error and idle-line detection
module uart_byte_receiver (
    input  logic       clock,
    input  logic       reset,
    input  logic       fpga_rxd,
    input  logic [9:0] cpd,
    input  logic [9:0] timer_cap,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       framing_error,
    output logic       rx_busy,
    output logic       line_idle
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic       rxd_m;
    logic       rxd_s;
    logic [9:0] cpd_l;
    logic [9:0] half_l;
    logic [9:0] bit_cnt;
    logic [9:0] idle_cnt;
    logic [2:0] bit_idx;
    logic [7:0] shift_reg;
    logic       half_done;
    logic       bit_done;
    logic       latch_cpd;
    logic       clr_cnt;
    logic       sample_bit;
    logic       load_byte;
    logic       flag_frame;

    assign half_l    = {1'b0, cpd_l[9:1]};
    assign half_done = (bit_cnt == half_l - 10'd1);
    assign bit_done  = (bit_cnt == cpd_l - 10'd1);

    always_comb begin
        state_nxt  = state;
        latch_cpd  = 1'b0;
        clr_cnt    = 1'b0;
        sample_bit = 1'b0;
        load_byte  = 1'b0;
        flag_frame = 1'b0;
        case (state)
            IDLE: begin
                if (!rxd_s) begin
                    state_nxt = START;
                    latch_cpd = 1'b1;
                    clr_cnt   = 1'b1;
                end
            end
            START: begin
                // Mid-start-bit check rejects glitches shorter than half a bit.
                if (half_done) begin
                    clr_cnt   = 1'b1;
                    state_nxt = rxd_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (bit_done) begin
                    clr_cnt    = 1'b1;
                    sample_bit = 1'b1;
                    if (bit_idx == 3'd7) begin
                        state_nxt = STOP;
                    end
                end
            end
            STOP: begin
                if (bit_done) begin
                    clr_cnt = 1'b1;
                    if (rxd_s) begin
                        load_byte = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        flag_frame = 1'b1;
                        state_nxt  = BREAK;
                    end
                end
            end
            BREAK: begin
                if (rxd_s) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rxd_m         <= 1'b1;
            rxd_s         <= 1'b1;
            state         <= IDLE;
            cpd_l         <= 10'd4;
            bit_cnt       <= 10'd0;
            bit_idx       <= 3'd0;
            shift_reg     <= 8'h00;
            idle_cnt      <= 10'd0;
            data_out      <= 8'h00;
            data_valid    <= 1'b0;
            framing_error <= 1'b0;
        end else begin
            rxd_m         <= fpga_rxd;
            rxd_s         <= rxd_m;
            state         <= state_nxt;
            data_valid    <= load_byte;
            framing_error <= flag_frame;

            if (latch_cpd) begin
                cpd_l   <= (cpd < 10'd4) ? 10'd4 : cpd;
                bit_idx <= 3'd0;
            end else if (sample_bit) begin
                bit_idx <= bit_idx + 3'd1;
            end

            if (clr_cnt) begin
                bit_cnt <= 10'd0;
            end else if (state == START || state == DATA || state == STOP) begin
                bit_cnt <= bit_cnt + 10'd1;
            end

            if (sample_bit) begin
                shift_reg <= {rxd_s, shift_reg[7:1]};
            end

            if (load_byte) begin
                data_out <= shift_reg;
            end

            // Idle timer saturates at the cap, re-clamping if the cap is lowered.
            if (latch_cpd) begin
                idle_cnt <= 10'd0;
            end else if (state == IDLE) begin
                if (idle_cnt > timer_cap) begin
                    idle_cnt <= timer_cap;
                end else if (rxd_s && idle_cnt < timer_cap) begin
                    idle_cnt <= idle_cnt + 10'd1;
                end
            end
        end
    end

    assign rx_busy   = (state != IDLE);
    assign line_idle = (state == IDLE) && (timer_cap != 10'd0) && (idle_cnt == timer_cap);

endmodule

// File: tb/tb_uart_byte_receiver.sv
// tb/tb_uart_byte_receiver.sv - scoreboard bench for uart_byte_receiver
module tb_uart_byte_receiver;

    logic       clock;
    logic       reset;
    logic       fpga_rxd;
    logic [9:0] cpd;
    logic [9:0] timer_cap;
    logic [7:0] data_out;
    logic       data_valid;
    logic       framing_error;
    logic       rx_busy;
    logic       line_idle;

    typedef struct {
        bit         is_err;
        logic [7:0] data;
    } sb_item_t;

    sb_item_t   exp_q[$];
    int         n_checks;
    int         n_fail;
    logic [7:0] last_byte;
    logic       prev_strobe;

    uart_byte_receiver dut (
        .clock        (clock),
        .reset        (reset),
        .fpga_rxd     (fpga_rxd),
        .cpd          (cpd),
        .timer_cap    (timer_cap),
        .data_out     (data_out),
        .data_valid   (data_valid),
        .framing_error(framing_error),
        .rx_busy      (rx_busy),
        .line_idle    (line_idle)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic hold_line(input logic v, input int unsigned n);
        fpga_rxd = v;
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Reference: a frame at an effective period of max(cpd,4) yields its byte
    // when the stop bit is high and a framing error otherwise.
    task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int unsigned cpd_val,
                              input bit scramble_cpd, input bit watch_idle);
        int unsigned per;
        sb_item_t    it;
        per       = (cpd_val < 4) ? 4 : cpd_val;
        cpd       = cpd_val[9:0];
        it.is_err = !stop_ok;
        it.data   = b;
        exp_q.push_back(it);
        fpga_rxd  = 1'b0;
        for (int k = 1; k <= int'(per); k++) begin
            @(posedge clock);
            #1;
            if (watch_idle && k <= 3) begin
                check("idle_fall_line_idle", line_idle, (k < 3) ? 1 : 0);
                check("idle_fall_rx_busy", rx_busy, (k < 3) ? 0 : 1);
            end
        end
        if (scramble_cpd) cpd = 10'($urandom_range(0, 1023));
        for (int i = 0; i < 8; i++) hold_line(b[i], per);
        hold_line(stop_ok, per);
    endtask

    always @(negedge clock) begin
        sb_item_t e;
        if (rx_busy) check("busy_implies_not_idle", line_idle, 0);
        if (data_valid || framing_error) begin
            check("strobes_exclusive", data_valid & framing_error, 0);
            check("strobe_not_consecutive", prev_strobe, 0);
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", {data_valid, framing_error}, 0);
            end else begin
                e = exp_q.pop_front();
                check("strobe_kind", framing_error, e.is_err);
                if (e.is_err) begin
                    check("data_out_held_on_error", data_out, last_byte);
                end else begin
                    check("data_out", data_out, e.data);
                    last_byte = e.data;
                end
            end
        end
        prev_strobe = data_valid | framing_error;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  b;
        int unsigned c;
        bit          ok;
        int          waited;

        n_checks    = 0;
        n_fail      = 0;
        last_byte   = 8'h00;
        prev_strobe = 1'b0;
        reset       = 1'b1;
        fpga_rxd    = 1'b1;
        cpd         = 10'd11;
        timer_cap   = 10'd385;
        repeat (3) @(posedge clock);
        #1;
        check("reset_data_out", data_out, 8'h00);
        check("reset_data_valid", data_valid, 0);
        check("reset_framing_error", framing_error, 0);
        check("reset_rx_busy", rx_busy, 0);
        check("reset_line_idle", line_idle, 0);

        // Idle detect: line_idle rises on the 385th counted clock.
        reset = 1'b0;
        for (int k = 1; k <= 385; k++) begin
            @(posedge clock);
            #1;
            if (k == 384) check("idle_early", line_idle, 0);
            if (k == 385) check("idle_rise", line_idle, 1);
        end

        // Valid byte, also checking line_idle drops as the start bit is seen.
        send_frame(8'hA5, 1'b1, 11, 1'b0, 1'b1);
        hold_line(1'b1, 20);
        check("a5_data_out", data_out, 8'hA5);
        check("a5_line_idle_after", line_idle, 0);

        // Glitch of 3 clocks: START entered, then back to IDLE without a strobe.
        cpd = 10'd11;
        hold_line(1'b0, 3);
        check("glitch_start_entered", rx_busy, 1);
        hold_line(1'b1, 20);
        check("glitch_back_idle", rx_busy, 0);
        check("glitch_data_out", data_out, 8'hA5);

        // Bad stop bit followed by a held-low line.
        send_frame(8'h3C, 1'b0, 11, 1'b0, 1'b0);
        for (int k = 0; k < 40; k++) begin
            hold_line(1'b0, 1);
            check("break_busy", rx_busy, 1);
        end
        hold_line(1'b1, 2);
        check("break_busy_sync", rx_busy, 1);
        hold_line(1'b1, 1);
        check("break_release", rx_busy, 0);
        check("break_data_out", data_out, 8'hA5);

        // Back-to-back frames with no gap.
        send_frame(8'h01, 1'b1, 11, 1'b0, 1'b0);
        send_frame(8'hFE, 1'b1, 11, 1'b0, 1'b0);
        hold_line(1'b1, 30);
        check("b2b_data_out", data_out, 8'hFE);

        // Reset during data bit 4 aborts the frame.
        cpd = 10'd11;
        b   = 8'h5A;
        hold_line(1'b0, 11);
        for (int i = 0; i < 4; i++) hold_line(b[i], 11);
        hold_line(b[4], 5);
        reset    = 1'b1;
        fpga_rxd = 1'b1;
        repeat (2) begin
            @(posedge clock);
            #1;
        end
        last_byte = 8'h00;
        reset     = 1'b0;
        hold_line(1'b1, 5);
        check("abort_data_out", data_out, 8'h00);
        check("abort_data_valid", data_valid, 0);
        check("abort_framing_error", framing_error, 0);
        check("abort_rx_busy", rx_busy, 0);
        check("abort_line_idle", line_idle, 0);
        send_frame(8'hC3, 1'b1, 11, 1'b0, 1'b0);
        hold_line(1'b1, 30);
        check("abort_next_frame", data_out, 8'hC3);

        // Randomized frames: varying period (including clamped cpd), gaps,
        // bad stop bits and cpd changes mid-frame.
        for (int n = 0; n < 40; n++) begin
            b  = 8'($urandom);
            c  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 3) : $urandom_range(4, 24);
            ok = ($urandom_range(0, 5) != 0);
            send_frame(b, ok, c, 1'($urandom_range(0, 1)), 1'b0);
            if (!ok) begin
                hold_line(1'b0, $urandom_range(0, 20));
                hold_line(1'b1, $urandom_range(2, 6));
            end else begin
                hold_line(1'b1, $urandom_range(0, 6));
            end
        end

        waited = 0;
        while (exp_q.size() != 0 && waited < 500) begin
            hold_line(1'b1, 1);
            waited++;
        end
        check("scoreboard_drained", exp_q.size(), 0);
        hold_line(1'b1, 5);
        check("final_rx_busy", rx_busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
